ahb_s2m_mux_n: RTL and testbench

//  Parametrised AHB slave-to-master response multiplexer for NUM_SLAVES slaves plus a built-in default slave.

---
 rtl/ahb_s2m_mux_n.sv | 170 +++++++++++++++++
 tb/tb_ahb_s2m_mux_n.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_s2m_mux_n.sv
// AHB slave-to-master response multiplexer with a built-in two-cycle ERROR default slave
// and a per-transfer wait-state watchdog that converts a hung slave into an ERROR response.
module ahb_s2m_mux_n #(
  parameter  int NUM_SLAVES = 4,
  parameter  int DATA_W     = 32,
  parameter  int RESP_W     = 2,
  parameter  int TIMEOUT    = 256,
  localparam int IDX_W      = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [NUM_SLAVES-1:0]        HSEL,
  input  logic                         HSEL_DEF,
  input  logic [1:0]                   HTRANS,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADY_S,
  input  logic [NUM_SLAVES*RESP_W-1:0] HRESP_S,
  input  logic                         TO_CLR,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic [RESP_W-1:0]            HRESP,
  output logic                         TO_FLAG,
  output logic [IDX_W-1:0]             TO_IDX
);

  localparam logic [RESP_W-1:0] RESP_OKAY  = RESP_W'(0);
  localparam logic [RESP_W-1:0] RESP_ERROR = RESP_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DERR1,
    ST_DERR2,
    ST_TERR1,
    ST_TERR2
  } state_e;

  state_e                  state_q, state_d;
  logic [NUM_SLAVES-1:0]   sel_q, sel_d;
  logic                    new_def_act;
  logic [IDX_W-1:0]        sel_idx;
  logic                    slave_hit;
  logic [DATA_W-1:0]       slv_rdata;
  logic                    slv_ready;
  logic [RESP_W-1:0]       slv_resp;
  logic                    to_hit;
  logic                    to_flag_q, to_flag_d;
  logic [IDX_W-1:0]        to_idx_q, to_idx_d;
  logic                    unused_htrans0;

  assign unused_htrans0 = HTRANS[0];

  // Only real-slave bits are kept: "nothing" and "default" look identical once in IDLE,
  // and an active default access is carried by the FSM instead. Multi-hot collapses to default.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    sel_d       = HSEL;
    new_def_act = HSEL_DEF & HTRANS[1];
    if (!$onehot0({HSEL_DEF, HSEL})) begin
      sel_d       = '0;
      new_def_act = HTRANS[1];
    end
  end

  always_comb begin
    sel_idx   = '0;
    slave_hit = 1'b0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (sel_q[i]) begin
        sel_idx   = IDX_W'(i);
        slave_hit = 1'b1;
      end
    end
  end

  assign slv_rdata = HRDATA_S[sel_idx*DATA_W +: DATA_W];
  assign slv_ready = HREADY_S[sel_idx];
  assign slv_resp  = HRESP_S[sel_idx*RESP_W +: RESP_W];

  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = RESP_OKAY;
    unique case (state_q)
      ST_IDLE: begin
        if (slave_hit) begin
          HRDATA = slv_rdata;
          HREADY = slv_ready;
          HRESP  = slv_resp;
        end
      end
      ST_DERR1, ST_TERR1: begin
        HREADY = 1'b0;
        HRESP  = RESP_ERROR;
      end
      ST_DERR2, ST_TERR2: HRESP = RESP_ERROR;
      default: ;
    endcase
  end

  // The FSM moves on the same edge that registers the address phase, so DERR1 is the first data-phase cycle.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (to_hit)                     state_d = ST_TERR1;
        else if (HREADY && new_def_act) state_d = ST_DERR1;
      end
      ST_DERR1:           state_d = ST_DERR2;
      ST_TERR1:           state_d = ST_TERR2;
      ST_DERR2, ST_TERR2: state_d = new_def_act ? ST_DERR1 : ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  if (TIMEOUT > 0) begin : g_wdog
    localparam int              CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    // Trip one cycle early so the ERROR's first cycle replaces the last allowed wait cycle.
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'((TIMEOUT >= 2) ? TIMEOUT - 2 : 0);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             waiting;

    assign waiting = (state_q == ST_IDLE) && slave_hit && !slv_ready;
    assign to_hit  = waiting && (wait_cnt_q >= CNT_TRIP);

    always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (HREADY)                             wait_cnt_d = '0;
      else if (waiting && wait_cnt_q != CNT_MAX) wait_cnt_d = wait_cnt_q + 1'b1;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) wait_cnt_q <= '0;
      else          wait_cnt_q <= wait_cnt_d;
    end
  end else begin : g_no_wdog
    assign to_hit = 1'b0;
  end

  always_comb begin
    to_flag_d = to_flag_q;
    to_idx_d  = to_idx_q;
    if (to_hit) begin
      to_flag_d = 1'b1;
      to_idx_d  = sel_idx;
    end else if (TO_CLR) begin
      to_flag_d = 1'b0;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      to_flag_q <= 1'b0;
      to_idx_q  <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
      state_q   <= state_d;
      to_flag_q <= to_flag_d;
      to_idx_q  <= to_idx_d;
      if (HREADY) sel_q <= sel_d;
    end
  end

  assign TO_FLAG = to_flag_q;
  assign TO_IDX  = to_idx_q;

endmodule

// File: tb/tb_ahb_s2m_mux_n.sv
// Directed self-checking bench for ahb_s2m_mux_n (4 slaves, 32-bit data, watchdog TIMEOUT=8).
// Inputs change 1ns after posedge; outputs are compared at negedge.
module tb_ahb_s2m_mux_n;

  localparam int NS = 4;
  localparam int DW = 32;
  localparam int RW = 2;

  localparam logic [DW-1:0] D0 = 32'h0A0A_0000;
  localparam logic [DW-1:0] D1 = 32'h1111_1111;
  localparam logic [DW-1:0] D2 = 32'h2222_2222;
  localparam logic [DW-1:0] D3 = 32'h3B3B_3B3B;

  logic             HCLK = 1'b0;
  logic             HRESETn;
  logic [NS-1:0]    HSEL;
  logic             HSEL_DEF;
  logic [1:0]       HTRANS;
  logic [NS*DW-1:0] HRDATA_S;
  logic [NS-1:0]    HREADY_S;
  logic [NS*RW-1:0] HRESP_S;
  logic             TO_CLR;
  logic [DW-1:0]    HRDATA;
  logic             HREADY;
  logic [RW-1:0]    HRESP;
  logic             TO_FLAG;
  logic [1:0]       TO_IDX;

  int errors = 0;
  int checks = 0;

  ahb_s2m_mux_n #(.NUM_SLAVES(NS), .DATA_W(DW), .RESP_W(RW), .TIMEOUT(8)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HSEL_DEF(HSEL_DEF), .HTRANS(HTRANS),
    .HRDATA_S(HRDATA_S), .HREADY_S(HREADY_S), .HRESP_S(HRESP_S), .TO_CLR(TO_CLR),
    .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP), .TO_FLAG(TO_FLAG), .TO_IDX(TO_IDX)
  );

  always #5 HCLK = ~HCLK;

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic sample;
    @(negedge HCLK);
  endtask

  // {HREADY, HRESP, HRDATA} packed for compact comparisons
  function automatic logic [34:0] bus();
    return {HREADY, HRESP, HRDATA};
  endfunction

  task automatic test_reset;
    logic [34:0] exp;
    HRESETn = 1'b0;
    #2;
    exp = {1'b1, 2'd0, 32'h0};
    checks++;
    if (bus() !== exp || TO_FLAG !== 1'b0 || TO_IDX !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: got bus=%h flag=%b idx=%0d want bus=%h flag=0 idx=0", bus(), TO_FLAG, TO_IDX, exp);
    end
    tick;
    tick;
    HRESETn = 1'b1;
  endtask

  task automatic test_reset_mid_derr;
    logic [34:0] exp;
    HSEL_DEF = 1'b1; HTRANS = 2'b10;
    tick;
    HSEL_DEF = 1'b0; HTRANS = 2'b00;
    sample;
    checks++;
    if ({HREADY, HRESP} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL derr1_before_reset: got %b want %b", {HREADY, HRESP}, {1'b0, 2'd1});
    end
    #1 HRESETn = 1'b0;
    #1;
    exp = {1'b1, 2'd0, 32'h0};
    checks++;
    if (bus() !== exp || TO_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_derr1: got bus=%h flag=%b want bus=%h flag=0", bus(), TO_FLAG, exp);
    end
    tick;
    sample;
    checks++;
    if (bus() !== exp || TO_FLAG !== 1'b0) begin
      errors++;
      $display("FAIL reset_next_cycle: got bus=%h flag=%b want bus=%h flag=0", bus(), TO_FLAG, exp);
    end
    tick;
    HRESETn = 1'b1;
    sample;
    checks++;
    if (bus() !== exp) begin
      errors++;
      $display("FAIL after_reset_release: got %h want %h", bus(), exp);
    end
    tick;
  endtask

  task automatic test_wait_states;
    HSEL = 4'b0100; HTRANS = 2'b10;
    HREADY_S[2] = 1'b0; HRDATA_S[2*DW +: DW] = 32'hCAFE_F00D;
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    for (int i = 0; i < 3; i++) begin
      sample;
      checks++;
      if ({HREADY, HRESP} !== {1'b0, 2'd0}) begin
        errors++;
        $display("FAIL s2_wait_%0d: got %b want %b", i, {HREADY, HRESP}, {1'b0, 2'd0});
      end
      tick;
    end
    HREADY_S[2] = 1'b1;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'hCAFE_F00D}) begin
      errors++;
      $display("FAIL s2_data: got %h want %h", bus(), {1'b1, 2'd0, 32'hCAFE_F00D});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL s2_then_idle: got %h want %h", bus(), {1'b1, 2'd0, 32'h0});
    end
    tick;
    HRDATA_S[2*DW +: DW] = D2;
  endtask

  task automatic test_default_slave;
    HSEL_DEF = 1'b1; HTRANS = 2'b10;
    tick;
    HTRANS = 2'b00;
    sample;
    checks++;
    if (bus() !== {1'b0, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL def_err1: got %h want %h", bus(), {1'b0, 2'd1, 32'h0});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL def_err2: got %h want %h", bus(), {1'b1, 2'd1, 32'h0});
    end
    tick;
    HSEL_DEF = 1'b0;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL def_idle_okay: got %h want %h", bus(), {1'b1, 2'd0, 32'h0});
    end
    tick;
  endtask

  task automatic test_timeout;
    HSEL = 4'b0010; HTRANS = 2'b10; HREADY_S[1] = 1'b0;
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    for (int i = 0; i < 7; i++) begin
      sample;
      checks++;
      if (bus() !== {1'b0, 2'd0, D1} || TO_FLAG !== 1'b0) begin
        errors++;
        $display("FAIL to_wait_%0d: got bus=%h flag=%b want bus=%h flag=0", i, bus(), TO_FLAG, {1'b0, 2'd0, D1});
      end
      tick;
    end
    sample;
    checks++;
    if (bus() !== {1'b0, 2'd1, 32'h0} || TO_FLAG !== 1'b1 || TO_IDX !== 2'd1) begin
      errors++;
      $display("FAIL to_terr1: got bus=%h flag=%b idx=%0d want bus=%h flag=1 idx=1", bus(), TO_FLAG, TO_IDX, {1'b0, 2'd1, 32'h0});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL to_terr2: got %h want %h", bus(), {1'b1, 2'd1, 32'h0});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'h0} || TO_FLAG !== 1'b1) begin
      errors++;
      $display("FAIL to_sticky: got bus=%h flag=%b want bus=%h flag=1", bus(), TO_FLAG, {1'b1, 2'd0, 32'h0});
    end
    tick;
    TO_CLR = 1'b1; HREADY_S[1] = 1'b1;
    tick;
    TO_CLR = 1'b0;
    sample;
    checks++;
    if (TO_FLAG !== 1'b0 || TO_IDX !== 2'd1) begin
      errors++;
      $display("FAIL to_clear: got flag=%b idx=%0d want flag=0 idx=1", TO_FLAG, TO_IDX);
    end
    tick;
  endtask

  task automatic test_multi_hot;
    HSEL = 4'b0101; HTRANS = 2'b10;
    tick;
    sample;
    checks++;
    if (bus() !== {1'b0, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL mh_err1: got %h want %h", bus(), {1'b0, 2'd1, 32'h0});
    end
    tick;
    HSEL = 4'b0000; HSEL_DEF = 1'b1; HTRANS = 2'b11;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL mh_err2: got %h want %h", bus(), {1'b1, 2'd1, 32'h0});
    end
    tick;
    HSEL_DEF = 1'b0; HTRANS = 2'b00;
    sample;
    checks++;
    if (bus() !== {1'b0, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL def_b2b_err1: got %h want %h", bus(), {1'b0, 2'd1, 32'h0});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd1, 32'h0}) begin
      errors++;
      $display("FAIL def_b2b_err2: got %h want %h", bus(), {1'b1, 2'd1, 32'h0});
    end
    tick;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL mh_back_idle: got %h want %h", bus(), {1'b1, 2'd0, 32'h0});
    end
    tick;
  endtask

  task automatic test_back_to_back;
    HSEL = 4'b0001; HTRANS = 2'b10;
    tick;
    HSEL = 4'b1000;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, D0}) begin
      errors++;
      $display("FAIL b2b_s0: got %h want %h", bus(), {1'b1, 2'd0, D0});
    end
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, D3}) begin
      errors++;
      $display("FAIL b2b_s3: got %h want %h", bus(), {1'b1, 2'd0, D3});
    end
    tick;
    HSEL = 4'b0001; HTRANS = 2'b10; HREADY_S[0] = 1'b0;
    tick;
    HSEL = 4'b1000;
    for (int i = 0; i < 2; i++) begin
      sample;
      checks++;
      if (bus() !== {1'b0, 2'd0, D0}) begin
        errors++;
        $display("FAIL s0_held_%0d: got %h want %h", i, bus(), {1'b0, 2'd0, D0});
      end
      tick;
    end
    HREADY_S[0] = 1'b1;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, D0}) begin
      errors++;
      $display("FAIL s0_release: got %h want %h", bus(), {1'b1, 2'd0, D0});
    end
    tick;
    HSEL = 4'b0000; HTRANS = 2'b00; HRESP_S[3*RW +: RW] = 2'd1;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd1, D3}) begin
      errors++;
      $display("FAIL s3_err_passthru: got %h want %h", bus(), {1'b1, 2'd1, D3});
    end
    tick;
    HRESP_S = '0;
    sample;
    checks++;
    if (bus() !== {1'b1, 2'd0, 32'h0}) begin
      errors++;
      $display("FAIL b2b_idle: got %h want %h", bus(), {1'b1, 2'd0, 32'h0});
    end
    tick;
  endtask

  initial begin
    HSEL     = '0;
    HSEL_DEF = 1'b0;
    HTRANS   = 2'b00;
    HRDATA_S = {D3, D2, D1, D0};
    HREADY_S = '1;
    HRESP_S  = '0;
    TO_CLR   = 1'b0;
    test_reset;
    test_reset_mid_derr;
    test_wait_states;
    test_default_slave;
    test_timeout;
    test_multi_hot;
    test_back_to_back;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
